// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and result-width helper for the
// pipelined ALU with its sequential divider.
package alu_pkg;

   localparam logic [3:0] ALU_ADD   = 4'h0;
   localparam logic [3:0] ALU_SUB   = 4'h1;
   localparam logic [3:0] ALU_MUL   = 4'h2;
   localparam logic [3:0] ALU_DIV   = 4'h3;
   localparam logic [3:0] ALU_AND   = 4'h4;
   localparam logic [3:0] ALU_OR    = 4'h5;
   localparam logic [3:0] ALU_NAND  = 4'h6;
   localparam logic [3:0] ALU_NOR   = 4'h7;
   localparam logic [3:0] ALU_XOR   = 4'h8;
   localparam logic [3:0] ALU_XNOR  = 4'h9;
   localparam logic [3:0] ALU_CMPEQ = 4'hA;
   localparam logic [3:0] ALU_CMPGT = 4'hB;
   localparam logic [3:0] ALU_CMPLT = 4'hC;
   localparam logic [3:0] ALU_SHR   = 4'hD;
   localparam logic [3:0] ALU_SHL   = 4'hE;
   localparam logic [3:0] ALU_NOP   = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_HOLD = 2'd2
   } aluState_e;

   function automatic int resultWidth(input int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/alu_seq_divider.sv
// Restoring unsigned divider: one quotient bit per clock, DATA_WIDTH steps.
// The final step's result is presented combinationally so it can be captured on the same edge.
module alu_seq_divider #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] dividend_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] quotient_o,
   output logic [DATA_WIDTH-1:0] remainder_o
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);

   logic          busy_q, busy_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  rem_q, rem_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [W-1:0]  div_q, div_d;

   logic [W:0]    trial;
   logic [W:0]    diff;
   logic          fits;
   logic [W-1:0]  stepRem;
   logic [W-1:0]  stepQuo;
   logic          lastStep;

   // Partial remainder stays below the divisor, so the trial fits in W+1 bits
   assign trial    = {rem_q, quo_q[W-1]};
   assign diff     = trial - {1'b0, div_q};
   assign fits     = ~diff[W];
   assign stepRem  = fits ? diff[W-1:0] : trial[W-1:0];
   assign stepQuo  = {quo_q[W-2:0], fits};
   assign lastStep = busy_q && (cnt_q == '0);

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      div_d  = div_q;
      if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = CW'(W - 1);
         rem_d  = '0;
         quo_d  = dividend_i;
         div_d  = divisor_i;
      end else if (busy_q) begin
         rem_d = stepRem;
         quo_d = stepQuo;
         cnt_d = cnt_q - 1'b1;
         if (lastStep) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         div_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         div_q  <= div_d;
      end
   end

   // After completion the registers keep the final result for a stalled consumer
   assign busy_o      = busy_q;
   assign done_o      = lastStep;
   assign quotient_o  = busy_q ? stepQuo : quo_q;
   assign remainder_o = busy_q ? stepRem : rem_q;

endmodule

// File: rtl/alu_pipe_divseq.sv
// System ALU with valid/ready on both sides: single-cycle ops load the output
// register on the accepting edge, divides run through the sequential divider.
module alu_pipe_divseq
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FUN_WIDTH  = 4
) (
   input  logic                                 CLK,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [DATA_WIDTH-1:0]                A,
   input  logic [DATA_WIDTH-1:0]                B,
   input  logic [FUN_WIDTH-1:0]                 ALU_FUN,
   output logic [resultWidth(DATA_WIDTH)-1:0]   ALU_OUT,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 flag_zero,
   output logic                                 flag_carry,
   output logic                                 div_err
);

   localparam int W  = DATA_WIDTH;
   localparam int RW = resultWidth(DATA_WIDTH);

   aluState_e     state_q, state_d;
   logic [RW-1:0] aluOut_q, aluOut_d;
   logic          outValid_q, outValid_d;
   logic          zero_q, zero_d;
   logic          carry_q, carry_d;
   logic          err_q, err_d;

   logic          funLegal;
   logic [3:0]    opc;
   logic [RW-1:0] aExt, bExt;
   logic [RW-1:0] scRes;
   logic          scCarry, scZero, scErr, scLegal;

   logic          outFree, inFire, divStart, loadSc, loadDiv;
   logic          divBusy, divDone;
   logic [W-1:0]  divQuo, divRem;
   logic [RW-1:0] divRes;

   // Opcodes wider than four bits are only legal when the upper bits are clear
   assign funLegal = (ALU_FUN >> 4) == '0;
   assign opc      = ALU_FUN[3:0];
   assign aExt     = {{W{1'b0}}, A};
   assign bExt     = {{W{1'b0}}, B};

   always_comb begin
      scRes   = '0;
      scCarry = 1'b0;
      scErr   = 1'b0;
      scLegal = funLegal;
      case (opc)
         ALU_ADD:   {scCarry, scRes} = {1'b0, aExt} + {1'b0, bExt};
         ALU_SUB:   {scCarry, scRes} = {1'b0, aExt} - {1'b0, bExt};
         ALU_MUL:   scRes = aExt * bExt;
         ALU_DIV: begin
            if (B == '0) begin
               scRes = {A, {W{1'b1}}};
               scErr = 1'b1;
            end
         end
         ALU_AND:   scRes = {{W{1'b0}}, A & B};
         ALU_OR:    scRes = {{W{1'b0}}, A | B};
         ALU_NAND:  scRes = {{W{1'b0}}, ~(A & B)};
         ALU_NOR:   scRes = {{W{1'b0}}, ~(A | B)};
         ALU_XOR:   scRes = {{W{1'b0}}, A ^ B};
         ALU_XNOR:  scRes = {{W{1'b0}}, ~(A ^ B)};
         ALU_CMPEQ: scRes = (A == B) ? RW'(1) : '0;
         ALU_CMPGT: scRes = (A > B)  ? RW'(2) : '0;
         ALU_CMPLT: scRes = (A < B)  ? RW'(3) : '0;
         ALU_SHR:   scRes = {{W{1'b0}}, A >> 1};
         ALU_SHL:   scRes = {{(W-1){1'b0}}, A, 1'b0};
         default:   scLegal = 1'b0;
      endcase
      if (!scLegal) begin
         scRes   = '0;
         scCarry = 1'b0;
         scErr   = 1'b0;
      end
      scZero = scLegal && (scRes == '0);
   end

   assign outFree  = !outValid_q || out_ready;
   assign in_ready = (state_q == ST_IDLE) && outFree;
   assign inFire   = in_valid && in_ready;
   assign divStart = inFire && funLegal && (opc == ALU_DIV) && (B != '0);

   alu_seq_divider #(
      .DATA_WIDTH (DATA_WIDTH)
   ) uDivider (
      .CLK         (CLK),
      .rst         (rst),
      .start_i     (divStart),
      .dividend_i  (A),
      .divisor_i   (B),
      .busy_o      (divBusy),
      .done_o      (divDone),
      .quotient_o  (divQuo),
      .remainder_o (divRem)
   );

   assign divRes = {divRem, divQuo};

   // A finished divide that cannot retire parks in HOLD; the divider keeps its result
   always_comb begin
      state_d = state_q;
      loadSc  = 1'b0;
      loadDiv = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (divStart) begin
               state_d = ST_DIV;
            end else if (inFire) begin
               loadSc = 1'b1;
            end
         end
         ST_DIV: begin
            if (divDone) begin
               if (outFree) begin
                  loadDiv = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HOLD;
               end
            end else if (!divBusy) begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (outFree) begin
               loadDiv = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      aluOut_d   = aluOut_q;
      outValid_d = outValid_q;
      zero_d     = zero_q;
      carry_d    = carry_q;
      err_d      = err_q;
      if (loadSc) begin
         aluOut_d   = scRes;
         outValid_d = 1'b1;
         zero_d     = scZero;
         carry_d    = scCarry;
         err_d      = scErr;
      end else if (loadDiv) begin
         aluOut_d   = divRes;
         outValid_d = 1'b1;
         zero_d     = (divRes == '0);
         carry_d    = 1'b0;
         err_d      = 1'b0;
      end else if (out_ready) begin
         outValid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         aluOut_q   <= '0;
         outValid_q <= 1'b0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         aluOut_q   <= aluOut_d;
         outValid_q <= outValid_d;
         zero_q     <= zero_d;
         carry_q    <= carry_d;
         err_q      <= err_d;
      end
   end

   assign ALU_OUT    = aluOut_q;
   assign out_valid  = outValid_q;
   assign flag_zero  = zero_q;
   assign flag_carry = carry_q;
   assign div_err    = err_q;

endmodule

// File: tb/tb_alu_pipe_divseq.sv
// Directed scoreboard bench for alu_pipe_divseq (W=8): expectations are queued
// when a request is driven and compared whenever a result retires.
module tb_alu_pipe_divseq;

   typedef struct packed {
      logic [15:0] res;
      logic        carry;
      logic        zero;
      logic        err;
   } exp_t;

   logic        CLK = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  A, B;
   logic [3:0]  ALU_FUN;
   logic [15:0] ALU_OUT;
   logic        out_valid;
   logic        out_ready;
   logic        flag_zero, flag_carry, div_err;

   int   compared   = 0;
   int   mismatched = 0;
   exp_t sbQ[$];
   exp_t cur;
   int   lowCount;
   logic [3:0] ops [0:9] = '{4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

   alu_pipe_divseq #(
      .DATA_WIDTH (8),
      .FUN_WIDTH  (4)
   ) dut (
      .CLK        (CLK),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .A          (A),
      .B          (B),
      .ALU_FUN    (ALU_FUN),
      .ALU_OUT    (ALU_OUT),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .flag_zero  (flag_zero),
      .flag_carry (flag_carry),
      .div_err    (div_err)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] r, input logic c, input logic z, input logic e);
      exp_t x;
      x.res = r; x.carry = c; x.zero = z; x.err = e;
      return x;
   endfunction

   // Reference behaviour in plain integer arithmetic
   function automatic exp_t model(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b);
      exp_t x;
      int ia, ib;
      ia = int'(a);
      ib = int'(b);
      x = '0;
      case (fun)
         4'h0: x.res = 16'(ia + ib);
         4'h1: begin x.res = 16'(ia - ib); x.carry = (ia < ib); end
         4'h2: x.res = 16'(ia * ib);
         4'h3: begin
            if (ib == 0) begin x.res = {a, 8'hFF}; x.err = 1'b1; end
            else x.res = {8'(ia % ib), 8'(ia / ib)};
         end
         4'h4: x.res = {8'h00, a & b};
         4'h5: x.res = {8'h00, a | b};
         4'h6: x.res = {8'h00, ~(a & b)};
         4'h7: x.res = {8'h00, ~(a | b)};
         4'h8: x.res = {8'h00, a ^ b};
         4'h9: x.res = {8'h00, ~(a ^ b)};
         4'hA: x.res = (ia == ib) ? 16'd1 : 16'd0;
         4'hB: x.res = (ia > ib) ? 16'd2 : 16'd0;
         4'hC: x.res = (ia < ib) ? 16'd3 : 16'd0;
         4'hD: x.res = 16'(ia / 2);
         4'hE: x.res = 16'(ia * 2);
         default: x.res = 16'd0;
      endcase
      x.zero = (fun != 4'hF) && (x.res == 16'd0);
      return x;
   endfunction

   // Scoreboard: a result retires at the next posedge when valid and ready are both high
   always @(negedge CLK) begin
      if (!rst && out_valid && out_ready) begin
         checkOutput("sb_nonempty", 32'(sbQ.size() != 0), 32'd1);
         if (sbQ.size() != 0) begin
            cur = sbQ.pop_front();
            checkOutput("out_res", 32'(ALU_OUT), 32'(cur.res));
            checkOutput("out_carry", 32'(flag_carry), 32'(cur.carry));
            checkOutput("out_zero", 32'(flag_zero), 32'(cur.zero));
            checkOutput("out_err", 32'(div_err), 32'(cur.err));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic applyStimulus(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b, input exp_t e);
      logic accepted;
      accepted = 1'b0;
      sbQ.push_back(e);
      in_valid = 1'b1;
      ALU_FUN  = fun;
      A        = a;
      B        = b;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (in_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      if (accepted) begin
         @(posedge CLK);
         #1;
      end
      in_valid = 1'b0;
      A        = 8'($urandom);
      B        = 8'($urandom);
      ALU_FUN  = 4'($urandom);
      checkOutput("accept", 32'(accepted), 32'd1);
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 40; i++) begin
         if (sbQ.size() == 0) break;
         @(negedge CLK);
         #1;
      end
      checkOutput("drain", 32'(sbQ.size()), 32'd0);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; ALU_FUN = '0;
      repeat (3) @(negedge CLK);
      checkOutput("rst_out", 32'(ALU_OUT), 32'd0);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_flags", 32'({flag_zero, flag_carry, div_err}), 32'd0);
      rst = 1'b0;
      @(posedge CLK);
      #1;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

      // Back-to-back single-cycle ops
      applyStimulus(4'h0, 8'hFF, 8'h01, mk(16'h0100, 1'b0, 1'b0, 1'b0));
      applyStimulus(4'h1, 8'h03, 8'h05, mk(16'hFFFE, 1'b1, 1'b0, 1'b0));
      applyStimulus(4'h2, 8'hFF, 8'hFF, mk(16'hFE01, 1'b0, 1'b0, 1'b0));
      waitDrain();

      // Multi-cycle divide: busy for W cycles
      applyStimulus(4'h3, 8'd200, 8'd7, mk({8'd4, 8'd28}, 1'b0, 1'b0, 1'b0));
      lowCount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (in_ready) break;
         lowCount++;
      end
      checkOutput("div_busy_cycles", 32'(lowCount), 32'd8);
      waitDrain();

      // Divide by zero completes in one cycle
      applyStimulus(4'h3, 8'd9, 8'd0, mk(16'h09FF, 1'b0, 1'b0, 1'b1));
      @(negedge CLK);
      checkOutput("divz_in_ready", 32'(in_ready), 32'd1);
      checkOutput("divz_valid", 32'(out_valid), 32'd1);
      waitDrain();

      // Remaining opcodes against the reference model
      for (int i = 0; i < 10; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom);
         rb = (i == 4) ? ra : 8'($urandom);
         applyStimulus(ops[i], ra, rb, model(ops[i], ra, rb));
      end
      applyStimulus(4'h1, 8'h5A, 8'h5A, model(4'h1, 8'h5A, 8'h5A));
      applyStimulus(4'h3, 8'hF1, 8'h0D, model(4'h3, 8'hF1, 8'h0D));
      waitDrain();

      // Consumer stall, then same-edge retire and load
      out_ready = 1'b0;
      applyStimulus(4'h8, 8'h3C, 8'h0F, mk(16'h0033, 1'b0, 1'b0, 1'b0));
      repeat (5) begin
         @(negedge CLK);
         checkOutput("stall_out", 32'(ALU_OUT), 32'h0033);
         checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge CLK);
      #1;
      out_ready = 1'b1;
      applyStimulus(4'h4, 8'hF0, 8'h0F, mk(16'h0000, 1'b0, 1'b1, 1'b0));
      waitDrain();

      // Divide finishing into a stalled consumer
      applyStimulus(4'h3, 8'd255, 8'd16, mk(16'h0F0F, 1'b0, 1'b0, 1'b0));
      out_ready = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         if (out_valid) break;
      end
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      repeat (3) begin
         @(negedge CLK);
         checkOutput("hold_out", 32'(ALU_OUT), 32'h0F0F);
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge CLK);
      #1;
      out_ready = 1'b1;
      waitDrain();

      // Reset in the middle of a divide drops it
      applyStimulus(4'h3, 8'd100, 8'd3, mk(16'h0121, 1'b0, 1'b0, 1'b0));
      repeat (4) @(negedge CLK);
      rst = 1'b1;
      #1;
      checkOutput("midrst_out", 32'(ALU_OUT), 32'd0);
      checkOutput("midrst_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_flags", 32'({flag_zero, flag_carry, div_err}), 32'd0);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      sbQ.delete();
      @(negedge CLK);
      rst = 1'b0;
      @(posedge CLK);
      #1;
      applyStimulus(4'hA, 8'd5, 8'd5, mk(16'h0001, 1'b0, 1'b0, 1'b0));
      waitDrain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
